// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
//
// Purpose:
//   Moore-style control FSM for the 32-bit multicycle MIPS datapath. It walks
//   each instruction through FETCH, DECODE and a short class-specific tail,
//   and it drives every datapath control strobe. Instructions take 3 to 5
//   cycles: lw = 5; R-type, addi, slti and sw = 4; beq, bne, j, jal and
//   jr = 3.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   synchronous, active-high reset (forces S_RST)
//   opc[5:0]     in   IR[31:26]
//   func[5:0]    in   IR[5:0]
//   zero         in   combinational ALU zero flag, used in BRANCH only
//   PCLoad       out  PC load enable (branch condition already folded in)
//   IorD         out  memory address select: 0=PC, 1=ALUOut
//   MemRead      out  memory read strobe
//   MemWrite     out  memory write strobe
//   IRWrite      out  IR load enable
//   RegDst       out  write register select: 0=rt, 1=rd
//   JalSig1      out  force the write register to r31
//   MemToReg     out  write data select: 0=MDR, 1=ALUOut
//   JalSig2      out  force the write data to PC
//   RegWrite     out  register file write enable
//   ALUSrcA      out  ALU A select: 0=PC, 1=A
//   ALUSrcB[1:0] out  ALU B select: 00=B, 01=4, 10=SE, 11=SE<<2
//   ALUOperation out  ALU operation code
//   PCSrc[1:0]   out  PC source: 00=ALU, 01=jump target, 10=ALUOut, 11=A
//   illegal      out  trap flag, high while the FSM sits in HALT
//
// Configuration macro:
//   MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
//     Defined:   an undecoded opcode sends DECODE to HALT. HALT raises illegal,
//                drops every strobe and is left only through rst.
//     Undefined: an undecoded opcode acts as a NOP and returns to FETCH.
//                illegal is tied to 0.
// ---------------------------------------------------------------------------
module multicycle_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opc,
  input  logic [5:0] func,
  input  logic       zero,
  output logic       PCLoad,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       JalSig1,
  output logic       MemToReg,
  output logic       JalSig2,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUOperation,
  output logic [1:0] PCSrc,
  output logic       illegal
);

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_JAL  = 6'b000011;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_SLTI = 6'b001010;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_JR   = 6'b001000;

  // HALT is part of the encoding in both builds. Without the trap macro,
  // nothing ever enters HALT.
  typedef enum logic [3:0] {
    S_RST,
    FETCH,
    DECODE,
    MEMADR,
    MEMRD,
    MEMWB,
    MEMWR,
    RTEXE,
    RTWB,
    IEXE,
    IWB,
    BRANCH,
    JUMP,
    JAL,
    JR,
    HALT
  } stateT;

  stateT state_q, state_d;

  // State register. rst is sampled only at the clock edge, so a reset that
  // arrives mid-instruction abandons that instruction at the next edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RST;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and output decode. Every strobe defaults to 0, so each state
  // only has to raise what it needs. Outputs depend on state alone, except
  // PCLoad in BRANCH, which also looks at zero. In RTEXE, an unknown func
  // falls back to ADD and still writes back in RTWB.
  always_comb begin
    state_d      = state_q;
    PCLoad       = 1'b0;
    IorD         = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    RegDst       = 1'b0;
    JalSig1      = 1'b0;
    MemToReg     = 1'b0;
    JalSig2      = 1'b0;
    RegWrite     = 1'b0;
    ALUSrcA      = 1'b0;
    ALUSrcB      = 2'b00;
    ALUOperation = ALU_AND;
    PCSrc        = 2'b00;

    case (state_q)
      S_RST: begin
        state_d = FETCH;
      end

      FETCH: begin
        MemRead      = 1'b1;
        IRWrite      = 1'b1;
        ALUSrcB      = 2'b01;
        ALUOperation = ALU_ADD;
        PCLoad       = 1'b1;
        state_d      = DECODE;
      end

      DECODE: begin
        ALUSrcB      = 2'b11;
        ALUOperation = ALU_ADD;
        case (opc)
          OP_LW, OP_SW:     state_d = MEMADR;
          OP_R:             state_d = (func == FN_JR) ? JR : RTEXE;
          OP_ADDI, OP_SLTI: state_d = IEXE;
          OP_BEQ, OP_BNE:   state_d = BRANCH;
          OP_J:             state_d = JUMP;
          OP_JAL:           state_d = JAL;
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
          default:          state_d = HALT;
`else
          default:          state_d = FETCH;
`endif
        endcase
      end

      MEMADR: begin
        ALUSrcA      = 1'b1;
        ALUSrcB      = 2'b10;
        ALUOperation = ALU_ADD;
        state_d      = (opc == OP_LW) ? MEMRD : MEMWR;
      end

      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        state_d = MEMWB;
      end

      MEMWB: begin
        RegWrite = 1'b1;
        state_d  = FETCH;
      end

      MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        state_d  = FETCH;
      end

      RTEXE: begin
        ALUSrcA = 1'b1;
        case (func)
          FN_ADD:  ALUOperation = ALU_ADD;
          FN_SUB:  ALUOperation = ALU_SUB;
          FN_AND:  ALUOperation = ALU_AND;
          FN_OR:   ALUOperation = ALU_OR;
          FN_SLT:  ALUOperation = ALU_SLT;
          default: ALUOperation = ALU_ADD;
        endcase
        state_d = RTWB;
      end

      RTWB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
        MemToReg = 1'b1;
        state_d  = FETCH;
      end

      IEXE: begin
        ALUSrcA      = 1'b1;
        ALUSrcB      = 2'b10;
        ALUOperation = (opc == OP_SLTI) ? ALU_SLT : ALU_ADD;
        state_d      = IWB;
      end

      IWB: begin
        RegWrite = 1'b1;
        MemToReg = 1'b1;
        state_d  = FETCH;
      end

      BRANCH: begin
        ALUSrcA      = 1'b1;
        ALUOperation = ALU_SUB;
        PCSrc        = 2'b10;
        PCLoad       = (opc == OP_BNE) ? ~zero : zero;
        state_d      = FETCH;
      end

      JUMP: begin
        PCSrc   = 2'b01;
        PCLoad  = 1'b1;
        state_d = FETCH;
      end

      // r31 takes PC+4 in this same cycle, while the PC loads the target.
      JAL: begin
        PCSrc    = 2'b01;
        PCLoad   = 1'b1;
        RegWrite = 1'b1;
        JalSig1  = 1'b1;
        JalSig2  = 1'b1;
        state_d  = FETCH;
      end

      JR: begin
        PCSrc   = 2'b11;
        PCLoad  = 1'b1;
        state_d = FETCH;
      end

      HALT: begin
        state_d = HALT;
      end

      default: begin
        state_d = S_RST;
      end
    endcase
  end

  // The trap flag comes straight from the state, so it stays glitch-free
  // and holds until rst.
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
  assign illegal = (state_q == HALT);
`else
  assign illegal = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// ---------------------------------------------------------------------------
// tb_multicycle_controller
//
// Self-checking bench for multicycle_controller. It feeds a random stream of
// instructions and expects each one to produce a fixed sequence of control
// words. The model builds that sequence from the instruction class: a common
// fetch/decode prologue plus a class-specific tail. The zero flag is
// randomised every cycle. Resets are dropped in at random points, and an
// illegal opcode either returns to fetch or traps, depending on
// MULTICYCLE_CTRL_ILLEGAL_TRAP_EN.
// ---------------------------------------------------------------------------
module tb_multicycle_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] opc;
  logic [5:0] func;
  logic       zero;
  logic       PCLoad, IorD, MemRead, MemWrite, IRWrite, RegDst, JalSig1;
  logic       MemToReg, JalSig2, RegWrite, ALUSrcA, illegal;
  logic [1:0] ALUSrcB, PCSrc;
  logic [2:0] ALUOperation;

  int checks   = 0;
  int failures = 0;

  // One control word holds every DUT output, so each cycle is a single
  // comparison.
  typedef struct packed {
    logic       pcLoad;
    logic       iorD;
    logic       memRead;
    logic       memWrite;
    logic       irWrite;
    logic       regDst;
    logic       jalSig1;
    logic       memToReg;
    logic       jalSig2;
    logic       regWrite;
    logic       aluSrcA;
    logic [1:0] aluSrcB;
    logic [2:0] aluOp;
    logic [1:0] pcSrc;
    logic       illegal;
  } ctrlT;

  ctrlT obs;
  ctrlT expQ[$];
  int   brQ[$];
  bit   haltAfter;

  assign obs = {PCLoad, IorD, MemRead, MemWrite, IRWrite, RegDst, JalSig1,
                MemToReg, JalSig2, RegWrite, ALUSrcA, ALUSrcB, ALUOperation,
                PCSrc, illegal};

  multicycle_controller dut (
    .clk(clk), .rst(rst), .opc(opc), .func(func), .zero(zero),
    .PCLoad(PCLoad), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegDst(RegDst), .JalSig1(JalSig1),
    .MemToReg(MemToReg), .JalSig2(JalSig2), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOperation(ALUOperation),
    .PCSrc(PCSrc), .illegal(illegal)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Compare one observed control word with the model and log any mismatch.
  task automatic checkOutput(input string tag, input ctrlT got, input ctrlT want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s: got=%b required=%b", tag, got, want);
    end
  endtask

  // Put an instruction on the IR fields.
  task automatic applyStimulus(input logic [5:0] o, input logic [5:0] f);
    opc  = o;
    func = f;
  endtask

  // ALU code for an R-type func. Any func not listed here computes an add.
  function automatic logic [2:0] rTypeAlu(input logic [5:0] f);
    case (f)
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  // Build the expected per-cycle control words for one instruction.
  // brQ marks cycles whose PCLoad follows zero: 1 = beq, 2 = bne.
  task automatic planInstr(input logic [5:0] o, input logic [5:0] f);
    ctrlT w;
    expQ.delete();
    brQ.delete();
    haltAfter = 1'b0;

    w = '0; w.memRead = 1; w.irWrite = 1; w.pcLoad = 1;
    w.aluSrcB = 2'b01; w.aluOp = 3'b010;
    expQ.push_back(w); brQ.push_back(0);

    w = '0; w.aluSrcB = 2'b11; w.aluOp = 3'b010;
    expQ.push_back(w); brQ.push_back(0);

    case (o)
      6'b100011, 6'b101011: begin
        w = '0; w.aluSrcA = 1; w.aluSrcB = 2'b10; w.aluOp = 3'b010;
        expQ.push_back(w); brQ.push_back(0);
        if (o == 6'b100011) begin
          w = '0; w.memRead = 1; w.iorD = 1;
          expQ.push_back(w); brQ.push_back(0);
          w = '0; w.regWrite = 1;
          expQ.push_back(w); brQ.push_back(0);
        end else begin
          w = '0; w.memWrite = 1; w.iorD = 1;
          expQ.push_back(w); brQ.push_back(0);
        end
      end
      6'b000000: begin
        if (f == 6'b001000) begin
          w = '0; w.pcSrc = 2'b11; w.pcLoad = 1;
          expQ.push_back(w); brQ.push_back(0);
        end else begin
          w = '0; w.aluSrcA = 1; w.aluOp = rTypeAlu(f);
          expQ.push_back(w); brQ.push_back(0);
          w = '0; w.regWrite = 1; w.regDst = 1; w.memToReg = 1;
          expQ.push_back(w); brQ.push_back(0);
        end
      end
      6'b001000, 6'b001010: begin
        w = '0; w.aluSrcA = 1; w.aluSrcB = 2'b10;
        w.aluOp = (o == 6'b001010) ? 3'b111 : 3'b010;
        expQ.push_back(w); brQ.push_back(0);
        w = '0; w.regWrite = 1; w.memToReg = 1;
        expQ.push_back(w); brQ.push_back(0);
      end
      6'b000100, 6'b000101: begin
        w = '0; w.aluSrcA = 1; w.aluOp = 3'b110; w.pcSrc = 2'b10;
        expQ.push_back(w); brQ.push_back((o == 6'b000100) ? 1 : 2);
      end
      6'b000010: begin
        w = '0; w.pcSrc = 2'b01; w.pcLoad = 1;
        expQ.push_back(w); brQ.push_back(0);
      end
      6'b000011: begin
        w = '0; w.pcSrc = 2'b01; w.pcLoad = 1; w.regWrite = 1;
        w.jalSig1 = 1; w.jalSig2 = 1;
        expQ.push_back(w); brQ.push_back(0);
      end
      default: begin
`ifdef MULTICYCLE_CTRL_ILLEGAL_TRAP_EN
        haltAfter = 1'b1;
`endif
      end
    endcase
  endtask

  // Pulse rst for one edge, check the all-zero reset cycle, and return just
  // after the edge that enters fetch.
  task automatic doReset(input string tag);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checkOutput(tag, obs, ctrlT'('0));
    @(posedge clk); #1;
  endtask

  // Run one random instruction. On entry and on exit the bench sits 1 ns
  // after the edge that starts a fetch cycle.
  task automatic runInstr(input int n);
    logic [5:0] o, f;
    ctrlT       want;
    int         r;
    logic [5:0] opTab[10];
    logic [5:0] fnTab[6];
    opTab = '{6'b000000, 6'b000000, 6'b100011, 6'b101011, 6'b000100,
              6'b000101, 6'b000010, 6'b000011, 6'b001000, 6'b001010};
    fnTab = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b001000};

    r = $urandom_range(0, 11);
    if (r < 10)       o = opTab[r];
    else if (r == 10) o = 6'b111111;
    else              o = 6'($urandom);
    r = $urandom_range(0, 6);
    f = (r < 6) ? fnTab[r] : 6'($urandom);

    applyStimulus(o, f);
    planInstr(o, f);

    for (int i = 0; i < expQ.size(); i++) begin
      zero = 1'($urandom_range(0, 1));
      #1;
      want = expQ[i];
      if (brQ[i] == 1) want.pcLoad = zero;
      if (brQ[i] == 2) want.pcLoad = ~zero;
      checkOutput($sformatf("instr%0d opc=%b func=%b cyc%0d", n, o, f, i), obs, want);
      if ($urandom_range(0, 59) == 0) begin
        doReset($sformatf("instr%0d midreset", n));
        return;
      end
      @(posedge clk); #1;
    end

    if (haltAfter) begin
      for (int k = 0; k < 3; k++) begin
        want = '0; want.illegal = 1'b1;
        #1;
        checkOutput($sformatf("instr%0d halt%0d", n, k), obs, want);
        @(posedge clk); #1;
      end
      doReset($sformatf("instr%0d haltreset", n));
    end
  endtask

  // Hold reset for two cycles, then run a long random instruction stream.
  initial begin
    rst  = 1'b1;
    zero = 1'b0;
    applyStimulus(6'b000000, 6'b000000);
    @(posedge clk); #1;
    checkOutput("reset cyc0", obs, ctrlT'('0));
    @(posedge clk); #1;
    checkOutput("reset cyc1", obs, ctrlT'('0));
    rst = 1'b0;
    @(posedge clk); #1;

    for (int n = 0; n < 400; n++) begin
      runInstr(n);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Moore-style control FSM that sequences the 32-bit multicycle MIPS datapath. Every datapath control strobe comes from this block.
- Inputs are opc/func, decoded from IR, and the ALU zero flag.
- Instantiated beside the datapath in the CPU top level.
- One instruction takes 3–5 cycles, with a shared memory for instructions and data.

Parameters:
- ALU_ADD, 3'b010, ALUOperation code for add
- ALU_SUB, 3'b110, ALUOperation code for subtract
- ALU_AND, 3'b000, ALUOperation code for AND
- ALU_OR, 3'b001, ALUOperation code for OR
- ALU_SLT, 3'b111, ALUOperation code for set-less-than

Ports:
- clk in 1 rising-edge clock
- rst in 1 synchronous, active-high reset
- opc in 6 IR[31:26]
- func in 6 IR[5:0]
- zero in 1 combinational ALU zero flag, same cycle
- PCLoad out 1 PC load enable (includes branch condition)
- IorD out 1 memory address select: 0=PC, 1=ALUOut
- MemRead out 1 memory read strobe
- MemWrite out 1 memory write strobe
- IRWrite out 1 IR load enable
- RegDst out 1 write-register select: 0=rt, 1=rd
- JalSig1 out 1 force write register to 31
- MemToReg out 1 write-data select: 0=MDR, 1=ALUOut
- JalSig2 out 1 force write data to PC
- RegWrite out 1 register file write enable
- ALUSrcA out 1 ALU A select: 0=PC, 1=A
- ALUSrcB out 2 ALU B select: 00=B, 01=4, 10=SE, 11=SE<<2
- ALUOperation out 3 ALU op code
- PCSrc out 2 PC source: 00=ALU result, 01=jump target, 10=ALUOut, 11=A
- illegal out 1 trap flag (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high. While rst is sampled high at a clk edge, state <= S_RST.
- S_RST: all outputs 0. On the first edge with rst=0, go to FETCH.
- Output rules:
  - Outputs are a pure function of state; PCLoad in BRANCH also depends on zero.
  - Any output not listed for a state is 0.
- Decoded opcodes:
  - R=000000, lw=100011, sw=101011, beq=000100, bne=000101
  - j=000010, jal=000011, addi=001000, slti=001010
- R-type func codes: add=100000, sub=100010, and=100100, or=100101, slt=101010, jr=001000.
- FETCH: MemRead, IorD=0, IRWrite, ALUSrcA=0, ALUSrcB=01, ADD, PCSrc=00, PCLoad. Next: DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ADD (branch target into ALUOut). Next state by opcode:
  - lw/sw -> MEMADR
  - R with func=jr -> JR; other R -> RTEXE
  - addi/slti -> IEXE
  - beq/bne -> BRANCH
  - j -> JUMP
  - jal -> JAL
  - anything else -> FETCH (acts as a NOP)
- MEMADR: ALUSrcA=1, ALUSrcB=10, ADD. Next: MEMRD for lw, MEMWR for sw.
- MEMRD: MemRead, IorD=1. Next: MEMWB.
- MEMWB: RegWrite, RegDst=0, MemToReg=0. Next: FETCH.
- MEMWR: MemWrite, IorD=1. Next: FETCH.
- RTEXE: ALUSrcA=1, ALUSrcB=00, ALUOperation from func. Unknown func gives ADD and still writes back. Next: RTWB.
- RTWB: RegWrite, RegDst=1, MemToReg=1. Next: FETCH.
- IEXE: ALUSrcA=1, ALUSrcB=10, ADD for addi, SLT for slti. Next: IWB.
- IWB: RegWrite, RegDst=0, MemToReg=1. Next: FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, SUB, PCSrc=10. PCLoad=zero for beq, ~zero for bne. Next: FETCH.
- JUMP: PCSrc=01, PCLoad. Next: FETCH.
- JAL: PCSrc=01, PCLoad, RegWrite, JalSig1, JalSig2. r31 receives PC+4 (the pre-edge PC) in the same cycle. Next: FETCH.
- JR: PCSrc=11, PCLoad. Next: FETCH.
- Latencies in cycles including FETCH:
  - lw=5
  - R/addi/slti/sw=4
  - beq/bne/j/jal/jr=3
- Reset mid-instruction: abandon the instruction at the next edge and go to S_RST. No strobes are issued in that cycle.
- Exclusivity: MemRead and MemWrite are never both 1. RegWrite and MemWrite are never both 1.

Optional Feature:
- Macro: MULTICYCLE_CTRL_ILLEGAL_TRAP_EN.
- Defined:
  - An undecoded opcode in DECODE goes to state HALT.
  - In HALT, all strobes are 0 and illegal=1.
  - HALT is left only through rst.
- Undefined:
  - Undecoded opcodes return to FETCH.
  - illegal is tied to 0.

Test Plan:
- Reset: rst=1 for 2 cycles, then 0 -> all outputs 0 during reset; cycle 1 after release shows MemRead=1, IRWrite=1, PCLoad=1, ALUSrcB=01.
- lw: opc=100011 -> state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB; IorD=1 in MEMRD; RegWrite=1 with MemToReg=0 in cycle 5.
- sub: opc=000000, func=100010 -> ALUOperation=110 in RTEXE; RTWB shows RegDst=1, MemToReg=1, RegWrite=1; total 4 cycles.
- beq/bne: beq with zero=1 -> PCLoad=1, PCSrc=10 in BRANCH; beq with zero=0 -> PCLoad=0; bne with zero=0 -> PCLoad=1.
- jal then jr: opc=000011 -> JAL shows PCSrc=01, JalSig1=1, JalSig2=1, RegWrite=1; then opc=0, func=001000 -> JR shows PCSrc=11, PCLoad=1, 3 cycles.
- Illegal opcode 111111: macro undefined -> back in FETCH after DECODE; macro defined -> illegal=1 held with all strobes 0 until rst.
